wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the in-order RV64 pipeline, sitting between the MEM stage and the register file. It holds one instruction and waits for load data when needed. It extracts and sign- or zero-extends load results, then drives the register-file write port and the diff-test/ebreak retire signals (pc_wb, instr_wb). It also keeps a 64-bit retired-instruction counter.

## Interface
- XLEN, 64, data/PC width
- INST_LEN, 32, instruction width
- REG_ADDR_W, 5, register index width

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_valid_i  in  1  MEM offers an instruction
- mem_ready_o  out  1  stage accepts this cycle
- mem_pc_i  in  XLEN  instruction PC
- mem_instr_i  in  INST_LEN  instruction word
- mem_rd_i  in  REG_ADDR_W  destination register
- mem_rd_wen_i  in  1  instruction writes rd
- mem_is_load_i  in  1  instruction is a load
- mem_ld_size_i  in  2  00 byte, 01 half, 10 word, 11 double
- mem_ld_unsigned_i  in  1  zero-extend load (LBU/LHU/LWU)
- mem_addr_lo_i  in  3  load address bits [2:0]
- mem_alu_res_i  in  XLEN  non-load result
- dmem_rvalid_i  in  1  load data valid (one-cycle pulse)
- dmem_rdata_i  in  XLEN  aligned doubleword read data
- wr_en_o  out  1  register-file write enable
- wr_addr_o  out  REG_ADDR_W  write index
- wr_data_o  out  XLEN  write data
- pc_wb_o  out  XLEN  retiring PC, 0 when nothing retires
- instr_wb_o  out  INST_LEN  retiring instruction, 0 when nothing retires
- minstret_o  out  64  retired-instruction count

## Operation
- States:
  - EMPTY: nothing held.
  - WAIT_LD: load accepted, data pending.
  - FULL: result held; retires this cycle.
- mem_ready_o = (state != WAIT_LD). FULL retires in the same cycle, so it accepts back-to-back.
- Accept = mem_valid_i && mem_ready_o. On accept, latch pc, instr, rd, rd_wen, ld_size, ld_unsigned and addr_lo.
- Accept transitions:
  - Non-load: latch mem_alu_res_i, go to FULL.
  - Load with dmem_rvalid_i high in the same cycle: extract from dmem_rdata_i, go to FULL.
  - Load otherwise: go to WAIT_LD.
- WAIT_LD: on dmem_rvalid_i, extract data and go to FULL; otherwise stay.
- FULL without accept: go to EMPTY.
- dmem_rvalid_i is ignored in EMPTY and FULL unless it coincides with a load accept.
- Load extraction, using a = addr_lo:
  - byte: rdata[8a+7:8a]
  - half: lane addr_lo[2:1], rdata[16*lane+15 : 16*lane]
  - word: lane addr_lo[2]
  - double: whole doubleword; addr_lo and unsigned are ignored.
  - Misaligned low bits are dropped.
  - Result is sign-extended to XLEN unless ld_unsigned, in which case it is zero-extended.
- Outputs in FULL:
  - wr_en_o = rd_wen.
  - wr_addr_o = rd, wr_data_o = result.
  - pc_wb_o = pc, instr_wb_o = instr.
  - rd = 0 is still driven as-is; the register file discards writes to x0.
- Outputs in any other state: wr_en_o = 0, pc_wb_o = 0, instr_wb_o = 0. wr_addr_o and wr_data_o hold their last value.
- minstret_o increments by 1 in every FULL cycle and wraps from 2^64-1 to 0.

## Timing
- All outputs are registered and decoded from state; there are no combinational paths from inputs to outputs except mem_ready_o, which depends on state only.
- Non-load accepted at edge N: FULL during cycle N..N+1, and the register file writes at edge N+1.
- Load: FULL in the cycle after the edge that samples dmem_rvalid_i.
- Sustained non-load throughput: 1 instruction per cycle.
- Reset, asynchronous:
  - state = EMPTY, all outputs 0, minstret_o = 0, mem_ready_o = 1.
  - Reset during WAIT_LD abandons the load; a later stray dmem_rvalid_i is ignored.
- Each instruction's pc/instr is visible for exactly one cycle, so ebreak and diff-test trigger once.

## Test plan
- Reset, then back-to-back non-loads: ADDI x5 (result 0x1234), then x6 (result 0x5678) at consecutive cycles → wr_en_o pulses in 2 consecutive cycles with the right data, and minstret_o = 2.
- LB x7, addr_lo=3, rdata=0x0000_0000_8000_0000 (byte lane 3 = 0x80) → wr_data_o = 0xFFFF_FFFF_FFFF_FF80. Same with LBU → 0x80.
- LW with rvalid delayed 4 cycles → mem_ready_o = 0 for those cycles, then one FULL cycle. LWU lane 1 of 0x8765_4321_0000_0000 → wr_data_o = 0x8765_4321.
- Load accepted with dmem_rvalid_i high in the same cycle → FULL next cycle, with no WAIT_LD cycle.
- instr 0x00100073 retires → instr_wb_o = 0x00100073 for exactly one cycle, then 0. pc_wb_o is 0 whenever idle.
- Assert rst during WAIT_LD, then pulse dmem_rvalid_i → no write and minstret_o stays 0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage of the in-order RV64 pipeline: holds one instruction, waits for
// load data, extends load results and drives the register-file write port and retire trace.
module wb_stage #(
    parameter int XLEN       = 64,
    parameter int INST_LEN   = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [XLEN-1:0]       mem_pc_i,
    input  logic [INST_LEN-1:0]   mem_instr_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_rd_wen_i,
    input  logic                  mem_is_load_i,
    input  logic [1:0]            mem_ld_size_i,
    input  logic                  mem_ld_unsigned_i,
    input  logic [2:0]            mem_addr_lo_i,
    input  logic [XLEN-1:0]       mem_alu_res_i,

    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,

    output logic                  wr_en_o,
    output logic [REG_ADDR_W-1:0] wr_addr_o,
    output logic [XLEN-1:0]       wr_data_o,
    output logic [XLEN-1:0]       pc_wb_o,
    output logic [INST_LEN-1:0]   instr_wb_o,
    output logic [63:0]           minstret_o
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        WAIT_LD = 2'd1,
        FULL    = 2'd2
    } state_e;

    state_e                  state_q;

    logic [XLEN-1:0]         pc_q;
    logic [INST_LEN-1:0]     instr_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic                    rd_wen_q;
    logic [1:0]              ld_size_q;
    logic                    ld_unsigned_q;
    logic [2:0]              addr_lo_q;

    logic                    wr_en_q;
    logic [REG_ADDR_W-1:0]   wr_addr_q;
    logic [XLEN-1:0]         wr_data_q;
    logic [XLEN-1:0]         pc_wb_q;
    logic [INST_LEN-1:0]     instr_wb_q;
    logic [63:0]             minstret_q;

    logic                    accept;
    logic                    retire_d;
    logic [XLEN-1:0]         res_d;
    logic [XLEN-1:0]         pc_d;
    logic [INST_LEN-1:0]     instr_d;
    logic [REG_ADDR_W-1:0]   rd_d;
    logic                    rd_wen_d;

    // Misaligned low address bits fall away because each lane index is built from
    // only the address bits above the access size.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [1:0]      size,
        input logic            uns,
        input logic [2:0]      a,
        input logic [XLEN-1:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        b = rdata[{a, 3'b000} +: 8];
        h = rdata[{a[2:1], 4'b0000} +: 16];
        w = rdata[{a[2], 5'b00000} +: 32];
        case (size)
            2'b00:   extract_load = uns ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
            2'b01:   extract_load = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            2'b10:   extract_load = uns ? {{(XLEN-32){1'b0}}, w} : {{(XLEN-32){w[31]}}, w};
            default: extract_load = rdata;
        endcase
    endfunction

    assign mem_ready_o = (state_q != WAIT_LD);
    assign accept      = mem_valid_i && mem_ready_o;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        retire_d = 1'b0;
        res_d    = '0;
        pc_d     = pc_q;
        instr_d  = instr_q;
        rd_d     = rd_q;
        rd_wen_d = rd_wen_q;
        if (accept) begin
            pc_d     = mem_pc_i;
            instr_d  = mem_instr_i;
            rd_d     = mem_rd_i;
            rd_wen_d = mem_rd_wen_i;
            if (!mem_is_load_i) begin
                retire_d = 1'b1;
                res_d    = mem_alu_res_i;
            end else if (dmem_rvalid_i) begin
                retire_d = 1'b1;
                res_d    = extract_load(mem_ld_size_i, mem_ld_unsigned_i,
                                        mem_addr_lo_i, dmem_rdata_i);
            end
        end else if (state_q == WAIT_LD && dmem_rvalid_i) begin
            retire_d = 1'b1;
            res_d    = extract_load(ld_size_q, ld_unsigned_q, addr_lo_q, dmem_rdata_i);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= EMPTY;
            pc_q          <= '0;
            instr_q       <= '0;
            rd_q          <= '0;
            rd_wen_q      <= 1'b0;
            ld_size_q     <= '0;
            ld_unsigned_q <= 1'b0;
            addr_lo_q     <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            pc_wb_q       <= '0;
            instr_wb_q    <= '0;
            minstret_q    <= '0;
        end else begin
            if (accept) begin
                pc_q          <= mem_pc_i;
                instr_q       <= mem_instr_i;
                rd_q          <= mem_rd_i;
                rd_wen_q      <= mem_rd_wen_i;
                ld_size_q     <= mem_ld_size_i;
                ld_unsigned_q <= mem_ld_unsigned_i;
                addr_lo_q     <= mem_addr_lo_i;
            end

            if (retire_d) begin
                state_q <= FULL;
            end else if (accept || state_q == WAIT_LD) begin
                state_q <= WAIT_LD;
            end else begin
                state_q <= EMPTY;
            end

            // Trace outputs are zero whenever nothing retires; the write port
            // address and data keep their last value.
            wr_en_q    <= retire_d && rd_wen_d;
            pc_wb_q    <= retire_d ? pc_d : '0;
            instr_wb_q <= retire_d ? instr_d : '0;
            if (retire_d) begin
                wr_addr_q <= rd_d;
                wr_data_q <= res_d;
            end

            if (state_q == FULL) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign pc_wb_o    = pc_wb_q;
    assign instr_wb_o = instr_wb_q;
    assign minstret_o = minstret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_wb_stage;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  lo;
        logic [63:0] alu;
        logic        rv;
        logic [63:0] rdata;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        exp_en;
        logic [63:0] exp_data;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [63:0] mem_pc_i;
    logic [31:0] mem_instr_i;
    logic [4:0]  mem_rd_i;
    logic        mem_rd_wen_i;
    logic        mem_is_load_i;
    logic [1:0]  mem_ld_size_i;
    logic        mem_ld_unsigned_i;
    logic [2:0]  mem_addr_lo_i;
    logic [63:0] mem_alu_res_i;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic        wr_en_o;
    logic [4:0]  wr_addr_o;
    logic [63:0] wr_data_o;
    logic [63:0] pc_wb_o;
    logic [31:0] instr_wb_o;
    logic [63:0] minstret_o;

    int n_checks = 0;
    int n_pass   = 0;

    wb_stage dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid_i       (mem_valid_i),
        .mem_ready_o       (mem_ready_o),
        .mem_pc_i          (mem_pc_i),
        .mem_instr_i       (mem_instr_i),
        .mem_rd_i          (mem_rd_i),
        .mem_rd_wen_i      (mem_rd_wen_i),
        .mem_is_load_i     (mem_is_load_i),
        .mem_ld_size_i     (mem_ld_size_i),
        .mem_ld_unsigned_i (mem_ld_unsigned_i),
        .mem_addr_lo_i     (mem_addr_lo_i),
        .mem_alu_res_i     (mem_alu_res_i),
        .dmem_rvalid_i     (dmem_rvalid_i),
        .dmem_rdata_i      (dmem_rdata_i),
        .wr_en_o           (wr_en_o),
        .wr_addr_o         (wr_addr_o),
        .wr_data_o         (wr_data_o),
        .pc_wb_o           (pc_wb_o),
        .instr_wb_o        (instr_wb_o),
        .minstret_o        (minstret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic stim_t mk(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                                 input logic [4:0] rd, input logic wen, input logic ld,
                                 input logic [1:0] size, input logic uns, input logic [2:0] lo,
                                 input logic [63:0] alu, input logic rv, input logic [63:0] rdata);
        stim_t s;
        s.valid = v;   s.pc = pc;     s.instr = instr; s.rd = rd;
        s.wen = wen;   s.ld = ld;     s.size = size;   s.uns = uns;
        s.lo = lo;     s.alu = alu;   s.rv = rv;       s.rdata = rdata;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        mem_valid_i       = s.valid;
        mem_pc_i          = s.pc;
        mem_instr_i       = s.instr;
        mem_rd_i          = s.rd;
        mem_rd_wen_i      = s.wen;
        mem_is_load_i     = s.ld;
        mem_ld_size_i     = s.size;
        mem_ld_unsigned_i = s.uns;
        mem_addr_lo_i     = s.lo;
        mem_alu_res_i     = s.alu;
        dmem_rvalid_i     = s.rv;
        dmem_rdata_i      = s.rdata;
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic apply(input stim_t s);
        drive(s);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference load extraction: shift/mask arithmetic on the naturally aligned
    // element containing the address, then sign-fill above the element width.
    function automatic logic [63:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [2:0] lo, input logic [63:0] d);
        int nbytes;
        int off;
        logic [63:0] mask;
        logic [63:0] v;
        nbytes = 1 << size;
        if (nbytes == 8) return d;
        off  = (int'(lo) / nbytes) * nbytes;
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        v    = (d >> (8 * off)) & mask;
        if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
        return v;
    endfunction

    vec_t  tbl [10];
    stim_t idle;
    stim_t s;
    stim_t pend;
    stim_t r;
    logic        pend_v;
    logic        ret_v;
    logic [63:0] r_data;
    logic [63:0] m_mi;
    logic [4:0]  last_addr;
    logic [63:0] last_data;

    initial begin
        idle = '0;
        tbl[0] = '{mk(1, 64'h100, 32'h23400293, 5'd5, 1, 0, 2'd0, 0, 3'd0, 64'h1234, 0, 64'h0), 1'b1, 64'h1234};
        tbl[1] = '{mk(1, 64'h104, 32'h56780313, 5'd6, 1, 0, 2'd0, 0, 3'd0, 64'h5678, 0, 64'h0), 1'b1, 64'h5678};
        tbl[2] = '{mk(1, 64'h108, 32'h00318383, 5'd7, 1, 1, 2'd0, 0, 3'd3, 64'hBAD, 1, 64'h0000_0000_8000_0000), 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        tbl[3] = '{mk(1, 64'h10C, 32'h0031C383, 5'd7, 1, 1, 2'd0, 1, 3'd3, 64'hBAD, 1, 64'h0000_0000_8000_0000), 1'b1, 64'h80};
        tbl[4] = '{mk(1, 64'h110, 32'h00619403, 5'd8, 1, 1, 2'd1, 0, 3'd6, 64'hBAD, 1, 64'h8001_0000_0000_0000), 1'b1, 64'hFFFF_FFFF_FFFF_8001};
        tbl[5] = '{mk(1, 64'h114, 32'h0031D403, 5'd8, 1, 1, 2'd1, 1, 3'd3, 64'hBAD, 1, 64'h0000_0000_ABCD_0000), 1'b1, 64'hABCD};
        tbl[6] = '{mk(1, 64'h118, 32'h0041A483, 5'd9, 1, 1, 2'd2, 0, 3'd4, 64'hBAD, 1, 64'h8765_4321_0000_0000), 1'b1, 64'hFFFF_FFFF_8765_4321};
        tbl[7] = '{mk(1, 64'h11C, 32'h0051B503, 5'd10, 1, 1, 2'd3, 1, 3'd5, 64'hBAD, 1, 64'hDEAD_BEEF_0123_4567), 1'b1, 64'hDEAD_BEEF_0123_4567};
        tbl[8] = '{mk(1, 64'h120, 32'hFFF00013, 5'd0, 1, 0, 2'd0, 0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[9] = '{mk(1, 64'h124, 32'h04200593, 5'd11, 0, 0, 2'd0, 0, 3'd0, 64'h42, 0, 64'h0), 1'b0, 64'h42};

        rst = 1'b1;
        drive(idle);
        #12;
        check("reset_ready", mem_ready_o, 1);
        check("reset_wr_en", wr_en_o, 0);
        check("reset_wr_addr", wr_addr_o, 0);
        check("reset_wr_data", wr_data_o, 0);
        check("reset_pc_wb", pc_wb_o, 0);
        check("reset_instr_wb", instr_wb_o, 0);
        check("reset_minstret", minstret_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back vectors: each retires in the cycle after its accept edge.
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].s);
            check($sformatf("tbl%0d_wr_en", i), wr_en_o, tbl[i].exp_en);
            check($sformatf("tbl%0d_wr_addr", i), wr_addr_o, tbl[i].s.rd);
            check($sformatf("tbl%0d_wr_data", i), wr_data_o, tbl[i].exp_data);
            check($sformatf("tbl%0d_pc_wb", i), pc_wb_o, tbl[i].s.pc);
            check($sformatf("tbl%0d_instr_wb", i), instr_wb_o, tbl[i].s.instr);
            check($sformatf("tbl%0d_ready", i), mem_ready_o, 1);
            check($sformatf("tbl%0d_minstret", i), minstret_o, 64'(i));
        end
        apply(idle);
        check("tbl_idle_wr_en", wr_en_o, 0);
        check("tbl_idle_pc_wb", pc_wb_o, 0);
        check("tbl_idle_instr_wb", instr_wb_o, 0);
        check("tbl_idle_minstret", minstret_o, 10);

        // LWU whose data arrives four cycles late; a competing offer must be stalled.
        apply(mk(1, 64'h2000, 32'h0042E483, 5'd9, 1, 1, 2'd2, 1, 3'd4, 64'hBAD, 0, 64'h0));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ldwait%0d_ready", k), mem_ready_o, 0);
            check($sformatf("ldwait%0d_wr_en", k), wr_en_o, 0);
            check($sformatf("ldwait%0d_pc_wb", k), pc_wb_o, 0);
            if (k == 3)
                apply(mk(0, 64'h0, 32'h0, 5'd0, 0, 0, 2'd0, 0, 3'd0, 64'h0, 1, 64'h8765_4321_0000_0000));
            else
                apply(mk(1, 64'h9999, 32'h00000013, 5'd3, 1, 0, 2'd0, 0, 3'd0, 64'h77, 0, 64'h1111_2222_3333_4444));
        end
        check("ldwait_done_wr_en", wr_en_o, 1);
        check("ldwait_done_wr_addr", wr_addr_o, 9);
        check("ldwait_done_wr_data", wr_data_o, 64'h8765_4321);
        check("ldwait_done_pc_wb", pc_wb_o, 64'h2000);
        check("ldwait_done_ready", mem_ready_o, 1);
        check("ldwait_done_minstret", minstret_o, 10);
        apply(idle);
        check("ldwait_after_wr_en", wr_en_o, 0);
        check("ldwait_after_pc_wb", pc_wb_o, 0);
        check("ldwait_after_data_hold", wr_data_o, 64'h8765_4321);
        check("ldwait_after_addr_hold", wr_addr_o, 9);
        check("ldwait_after_minstret", minstret_o, 11);

        // ebreak is visible on the trace for exactly one cycle.
        apply(mk(1, 64'h3000, 32'h00100073, 5'd0, 0, 0, 2'd0, 0, 3'd0, 64'h0, 0, 64'h0));
        check("ebreak_instr_wb", instr_wb_o, 32'h00100073);
        check("ebreak_pc_wb", pc_wb_o, 64'h3000);
        check("ebreak_wr_en", wr_en_o, 0);
        apply(idle);
        check("ebreak_after_instr_wb", instr_wb_o, 0);
        check("ebreak_after_pc_wb", pc_wb_o, 0);
        check("ebreak_after_minstret", minstret_o, 12);

        // Reset while a load is pending; the late data pulse must be dropped.
        apply(mk(1, 64'h4000, 32'h00052283, 5'd5, 1, 1, 2'd2, 0, 3'd0, 64'h0, 0, 64'h0));
        check("rstld_wait_ready", mem_ready_o, 0);
        #2 rst = 1'b1;
        #1;
        check("rstld_ready", mem_ready_o, 1);
        check("rstld_minstret", minstret_o, 0);
        check("rstld_wr_data", wr_data_o, 0);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(0, 64'h0, 32'h0, 5'd0, 0, 0, 2'd0, 0, 3'd0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF));
        check("rstld_stray_wr_en", wr_en_o, 0);
        check("rstld_stray_pc_wb", pc_wb_o, 0);
        check("rstld_stray_ready", mem_ready_o, 1);
        apply(idle);
        check("rstld_stray_minstret", minstret_o, 0);
        check("rstld_stray_wr_en2", wr_en_o, 0);

        // Randomized traffic against a transaction-level model.
        pend_v    = 1'b0;
        pend      = '0;
        ret_v     = 1'b0;
        r         = '0;
        r_data    = '0;
        m_mi      = '0;
        last_addr = '0;
        last_data = '0;
        for (int n = 0; n < 3000; n++) begin
            s.valid = ($urandom_range(0, 99) < 70);
            s.pc    = {$urandom(), $urandom()};
            s.instr = $urandom();
            s.rd    = 5'($urandom_range(0, 31));
            s.wen   = ($urandom_range(0, 99) < 80);
            s.ld    = ($urandom_range(0, 99) < 45);
            s.size  = 2'($urandom_range(0, 3));
            s.uns   = 1'($urandom_range(0, 1));
            s.lo    = 3'($urandom_range(0, 7));
            s.alu   = {$urandom(), $urandom()};
            s.rv    = ($urandom_range(0, 99) < 40);
            s.rdata = {$urandom(), $urandom()};

            if (ret_v) m_mi = m_mi + 64'd1;
            ret_v = 1'b0;
            if (s.valid && !pend_v) begin
                if (!s.ld) begin
                    ret_v = 1'b1; r = s; r_data = s.alu;
                end else if (s.rv) begin
                    ret_v = 1'b1; r = s; r_data = ref_load(s.size, s.uns, s.lo, s.rdata);
                end else begin
                    pend_v = 1'b1; pend = s;
                end
            end else if (pend_v && s.rv) begin
                ret_v = 1'b1; r = pend; pend_v = 1'b0;
                r_data = ref_load(pend.size, pend.uns, pend.lo, s.rdata);
            end
            if (ret_v) begin
                last_addr = r.rd;
                last_data = r_data;
            end

            apply(s);
            check("rnd_wr_en", wr_en_o, ret_v && r.wen);
            check("rnd_wr_addr", wr_addr_o, last_addr);
            check("rnd_wr_data", wr_data_o, last_data);
            check("rnd_pc_wb", pc_wb_o, ret_v ? r.pc : 64'h0);
            check("rnd_instr_wb", instr_wb_o, ret_v ? r.instr : 32'h0);
            check("rnd_ready", mem_ready_o, !pend_v);
            check("rnd_minstret", minstret_o, m_mi);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
